// File: rtl/csr_trap_unit.sv
// csr_trap_unit: sole driver of the csr_regfile port; sequences Zicsr
// read-modify-write ops, machine trap entry and MRET, then redirects fetch.
module csr_trap_unit (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        csr_op_valid,
    input  logic [1:0]  csr_op,
    input  logic [11:0] csr_op_addr,
    input  logic [31:0] csr_op_src,
    input  logic        csr_op_wsup,
    output logic        csr_op_ready,
    output logic        csr_op_done,
    output logic [31:0] csr_op_rdata,
    input  logic        trap_req,
    input  logic [31:0] trap_cause,
    input  logic [31:0] trap_pc,
    input  logic [31:0] trap_val,
    input  logic        mret_req,
    output logic        busy,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic [11:0] csr_addr,
    output logic [31:0] csr_w_data,
    output logic        csr_w_en,
    input  logic [31:0] csr_r_data
);

    localparam logic [11:0] A_MSTATUS = 12'h300;
    localparam logic [11:0] A_MTVEC   = 12'h305;
    localparam logic [11:0] A_MEPC    = 12'h341;
    localparam logic [11:0] A_MCAUSE  = 12'h342;
    localparam logic [11:0] A_MTVAL   = 12'h343;

    typedef enum logic [3:0] {
        S_IDLE,
        S_CSR_WR,
        S_T_EPC,
        S_T_CAUSE,
        S_T_TVAL,
        S_T_STATUS,
        S_T_VEC,
        S_M_STATUS,
        S_M_EPC
    } state_t;

    state_t      state_q, state_d;
    logic [11:0] addr_q, addr_d;
    logic [31:0] old_q, old_d;
    logic [31:0] new_q, new_d;
    logic        wr_q, wr_d;
    logic [31:0] cause_q, cause_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] val_q, val_d;
    logic        busy_q;
    logic        rv_q, rv_d;
    logic [31:0] rpc_q, rpc_d;

    logic        w_en_raw;
    logic [31:0] st_trap;
    logic [31:0] st_mret;
    logic [31:0] tvec_base;
    logic [31:0] tvec_tgt;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            old_q   <= '0;
            new_q   <= '0;
            wr_q    <= 1'b0;
            cause_q <= '0;
            pc_q    <= '0;
            val_q   <= '0;
            busy_q  <= 1'b0;
            rv_q    <= 1'b0;
            rpc_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            old_q   <= old_d;
            new_q   <= new_d;
            wr_q    <= wr_d;
            cause_q <= cause_d;
            pc_q    <= pc_d;
            val_q   <= val_d;
            busy_q  <= (state_d != S_IDLE);
            rv_q    <= rv_d;
            rpc_q   <= rpc_d;
        end
    end

    // Status rewrites and trap vector are derived from the live read data.
    always_comb begin
        st_trap        = csr_r_data;
        st_trap[7]     = csr_r_data[3];
        st_trap[3]     = 1'b0;
        st_trap[12:11] = 2'b11;
        st_mret        = csr_r_data;
        st_mret[3]     = csr_r_data[7];
        st_mret[7]     = 1'b1;
        st_mret[12:11] = 2'b11;
        tvec_base      = {csr_r_data[31:2], 2'b00};
        tvec_tgt       = tvec_base;
        if (csr_r_data[1:0] == 2'b01 && cause_q[31]) begin
            tvec_tgt = tvec_base + {cause_q[29:0], 2'b00};
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        old_d   = old_q;
        new_d   = new_q;
        wr_d    = wr_q;
        cause_d = cause_q;
        pc_d    = pc_q;
        val_d   = val_q;
        rv_d    = 1'b0;
        rpc_d   = rpc_q;
        unique case (state_q)
            S_IDLE: begin
                if (trap_req) begin
                    cause_d = trap_cause;
                    pc_d    = trap_pc;
                    val_d   = trap_val;
                    state_d = S_T_EPC;
                end else if (mret_req) begin
                    state_d = S_M_STATUS;
                end else if (csr_op_valid) begin
                    addr_d  = csr_op_addr;
                    old_d   = csr_r_data;
                    wr_d    = !csr_op_wsup && (csr_op != 2'b00);
                    unique case (csr_op)
                        2'b01:   new_d = csr_op_src;
                        2'b10:   new_d = csr_r_data | csr_op_src;
                        2'b11:   new_d = csr_r_data & ~csr_op_src;
                        default: new_d = csr_r_data;
                    endcase
                    state_d = S_CSR_WR;
                end
            end
            S_CSR_WR:   state_d = S_IDLE;
            S_T_EPC:    state_d = S_T_CAUSE;
            S_T_CAUSE:  state_d = S_T_TVAL;
            S_T_TVAL:   state_d = S_T_STATUS;
            S_T_STATUS: state_d = S_T_VEC;
            S_T_VEC: begin
                rv_d    = 1'b1;
                rpc_d   = tvec_tgt;
                state_d = S_IDLE;
            end
            S_M_STATUS: state_d = S_M_EPC;
            S_M_EPC: begin
                rv_d    = 1'b1;
                rpc_d   = csr_r_data & ~32'h3;
                state_d = S_IDLE;
            end
            default:    state_d = S_IDLE;
        endcase
    end

    always_comb begin
        csr_addr     = csr_op_addr;
        csr_w_data   = '0;
        w_en_raw     = 1'b0;
        csr_op_done  = 1'b0;
        csr_op_rdata = '0;
        unique case (state_q)
            S_IDLE: ;
            S_CSR_WR: begin
                csr_addr     = addr_q;
                csr_w_data   = new_q;
                w_en_raw     = wr_q;
                csr_op_done  = 1'b1;
                csr_op_rdata = old_q;
            end
            S_T_EPC: begin
                csr_addr   = A_MEPC;
                csr_w_data = pc_q & ~32'h3;
                w_en_raw   = 1'b1;
            end
            S_T_CAUSE: begin
                csr_addr   = A_MCAUSE;
                csr_w_data = cause_q;
                w_en_raw   = 1'b1;
            end
            S_T_TVAL: begin
                csr_addr   = A_MTVAL;
                csr_w_data = val_q;
                w_en_raw   = 1'b1;
            end
            S_T_STATUS: begin
                csr_addr   = A_MSTATUS;
                csr_w_data = st_trap;
                w_en_raw   = 1'b1;
            end
            S_T_VEC:    csr_addr = A_MTVEC;
            S_M_STATUS: begin
                csr_addr   = A_MSTATUS;
                csr_w_data = st_mret;
                w_en_raw   = 1'b1;
            end
            S_M_EPC:    csr_addr = A_MEPC;
            default: ;
        endcase
    end

    // Reset gates the write strobe so a reset edge never commits a write.
    assign csr_w_en       = w_en_raw & reset_n;
    assign csr_op_ready   = (state_q == S_IDLE) & !trap_req & !mret_req;
    assign busy           = busy_q;
    assign redirect_valid = rv_q;
    assign redirect_pc    = rpc_q;

endmodule

// File: tb/tb_csr_trap_unit.sv
// tb_csr_trap_unit: regfile environment, table vectors, hand-written
// trap/MRET/reset sequences and randomized traffic against a reference model.
module tb_csr_trap_unit;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        csr_op_valid;
    logic [1:0]  csr_op;
    logic [11:0] csr_op_addr;
    logic [31:0] csr_op_src;
    logic        csr_op_wsup;
    logic        csr_op_ready;
    logic        csr_op_done;
    logic [31:0] csr_op_rdata;
    logic        trap_req;
    logic [31:0] trap_cause;
    logic [31:0] trap_pc;
    logic [31:0] trap_val;
    logic        mret_req;
    logic        busy;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [11:0] csr_addr;
    logic [31:0] csr_w_data;
    logic        csr_w_en;
    logic [31:0] csr_r_data;

    always #5 clock = ~clock;

    csr_trap_unit dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .csr_op_valid   (csr_op_valid),
        .csr_op         (csr_op),
        .csr_op_addr    (csr_op_addr),
        .csr_op_src     (csr_op_src),
        .csr_op_wsup    (csr_op_wsup),
        .csr_op_ready   (csr_op_ready),
        .csr_op_done    (csr_op_done),
        .csr_op_rdata   (csr_op_rdata),
        .trap_req       (trap_req),
        .trap_cause     (trap_cause),
        .trap_pc        (trap_pc),
        .trap_val       (trap_val),
        .mret_req       (mret_req),
        .busy           (busy),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .csr_addr       (csr_addr),
        .csr_w_data     (csr_w_data),
        .csr_w_en       (csr_w_en),
        .csr_r_data     (csr_r_data)
    );

    typedef struct {
        int          c;
        logic [11:0] a;
        logic [31:0] d;
    } wr_t;

    typedef struct {
        logic [1:0]  op;
        logic [11:0] a;
        logic [31:0] src;
        logic        wsup;
        logic        pre_en;
        logic [31:0] pre;
        logic [31:0] rd;
        logic        we;
        logic [31:0] wd;
    } vec_t;

    logic [31:0] rf   [0:4095];
    logic [31:0] m_rf [0:4095];
    logic        pl_en;
    logic [11:0] pl_addr;
    logic [31:0] pl_data;
    int          cyc_cnt = 0;
    int          bad_idle = 0;
    int          bad_rst = 0;
    wr_t         wlog[$];
    wr_t         ew[$];
    int          errors = 0;
    int          checks = 0;

    assign csr_r_data = rf[csr_addr];

    always @(posedge clock) begin
        cyc_cnt <= cyc_cnt + 1;
        if (csr_w_en) begin
            wlog.push_back('{cyc_cnt, csr_addr, csr_w_data});
            rf[csr_addr] <= csr_w_data;
        end else if (pl_en) begin
            rf[pl_addr] <= pl_data;
        end
        if (csr_w_en && !busy) bad_idle <= bad_idle + 1;
        if (csr_w_en && !reset_n) bad_rst <= bad_rst + 1;
    end

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic preload(input logic [11:0] a, input logic [31:0] d);
        pl_en   = 1'b1;
        pl_addr = a;
        pl_data = d;
        m_rf[a] = d;
        cyc();
        pl_en   = 1'b0;
    endtask

    task automatic chk_log(input string nm);
        chk({nm, " nwr"}, 32'(wlog.size()), 32'(ew.size()));
        for (int i = 0; i < ew.size() && i < wlog.size(); i++) begin
            chk({nm, " wcyc"}, 32'(wlog[i].c), 32'(ew[i].c));
            chk({nm, " waddr"}, {20'h0, wlog[i].a}, {20'h0, ew[i].a});
            chk({nm, " wdata"}, wlog[i].d, ew[i].d);
        end
        wlog.delete();
        ew.delete();
    endtask

    task automatic run_csr(input string nm, input logic [1:0] op,
                           input logic [11:0] a, input logic [31:0] src,
                           input logic wsup, input logic [31:0] exp_rd,
                           output int base);
        csr_op_valid = 1'b1;
        csr_op       = op;
        csr_op_addr  = a;
        csr_op_src   = src;
        csr_op_wsup  = wsup;
        #1;
        chk({nm, " ready"}, 32'(csr_op_ready), 1);
        cyc();
        base         = cyc_cnt;
        csr_op_valid = 1'b0;
        chk({nm, " done"}, 32'(csr_op_done), 1);
        chk({nm, " rdata"}, csr_op_rdata, exp_rd);
        chk({nm, " busy"}, 32'(busy), 1);
        cyc();
        chk({nm, " done2"}, 32'(csr_op_done), 0);
        chk({nm, " idle"}, 32'(busy), 0);
    endtask

    task automatic run_trap(input string nm, input logic [31:0] cause,
                            input logic [31:0] pc, input logic [31:0] val,
                            input logic [31:0] exp_tgt, output int base);
        trap_req   = 1'b1;
        trap_cause = cause;
        trap_pc    = pc;
        trap_val   = val;
        cyc();
        base     = cyc_cnt;
        trap_req = 1'b0;
        for (int k = 0; k < 5; k++) begin
            chk({nm, " busy"}, 32'(busy), 1);
            chk({nm, " rv early"}, 32'(redirect_valid), 0);
            cyc();
        end
        chk({nm, " rv"}, 32'(redirect_valid), 1);
        chk({nm, " rpc"}, redirect_pc, exp_tgt);
        chk({nm, " idle"}, 32'(busy), 0);
        cyc();
        chk({nm, " rv pulse"}, 32'(redirect_valid), 0);
    endtask

    task automatic run_mret(input string nm, input logic [31:0] exp_tgt,
                            output int base);
        mret_req = 1'b1;
        cyc();
        base     = cyc_cnt;
        mret_req = 1'b0;
        for (int k = 0; k < 2; k++) begin
            chk({nm, " busy"}, 32'(busy), 1);
            chk({nm, " rv early"}, 32'(redirect_valid), 0);
            cyc();
        end
        chk({nm, " rv"}, 32'(redirect_valid), 1);
        chk({nm, " rpc"}, redirect_pc, exp_tgt);
        cyc();
        chk({nm, " rv pulse"}, 32'(redirect_valid), 0);
    endtask

    function automatic logic [31:0] m_csr(input logic [1:0] op,
                                          input logic [31:0] o,
                                          input logic [31:0] s);
        if (op == 2'd1) return s;
        if (op == 2'd2) return o | s;
        if (op == 2'd3) return o & ~s;
        return o;
    endfunction

    function automatic logic [31:0] m_trap_st(input logic [31:0] s);
        return (s & ~32'h1888) | 32'h1800 | ((s & 32'h8) << 4);
    endfunction

    function automatic logic [31:0] m_mret_st(input logic [31:0] s);
        return (s & ~32'h1888) | 32'h1880 | ((s & 32'h80) >> 4);
    endfunction

    function automatic logic [31:0] m_tgt(input logic [31:0] v,
                                          input logic [31:0] c);
        logic [31:0] t;
        t = v - (v % 4);
        if (v % 4 == 1 && c >= 32'h8000_0000)
            t = t + (c - 32'h8000_0000) * 4;
        return t;
    endfunction

    vec_t        tv [8];
    logic [11:0] alist [6];

    initial begin
        int          base;
        int          kind;
        logic [11:0] a;
        logic [31:0] d, s, v, o, nv, cs, tg;
        logic [1:0]  op;
        logic        ws, irq;

        tv[0] = '{2'd1, 12'h305, 32'h0000_1000, 1'b0, 1'b1, 32'h0, 32'h0, 1'b1, 32'h1000};
        tv[1] = '{2'd2, 12'h300, 32'h80, 1'b0, 1'b1, 32'h8, 32'h8, 1'b1, 32'h88};
        tv[2] = '{2'd3, 12'h300, 32'h80, 1'b1, 1'b0, 32'h0, 32'h88, 1'b0, 32'h0};
        tv[3] = '{2'd3, 12'h300, 32'h8, 1'b0, 1'b1, 32'h88, 32'h88, 1'b1, 32'h80};
        tv[4] = '{2'd0, 12'h341, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'h1234, 32'h1234, 1'b0, 32'h0};
        tv[5] = '{2'd1, 12'h342, 32'h5, 1'b1, 1'b1, 32'hA, 32'hA, 1'b0, 32'h0};
        tv[6] = '{2'd2, 12'h343, 32'hF0F0_0000, 1'b0, 1'b1, 32'hFFFF, 32'hFFFF, 1'b1, 32'hF0F0_FFFF};
        tv[7] = '{2'd3, 12'h340, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'hCAFE_BABE, 32'hCAFE_BABE, 1'b1, 32'h0};
        alist = '{12'h300, 12'h305, 12'h341, 12'h342, 12'h343, 12'h340};

        reset_n      = 1'b0;
        pl_en        = 1'b0;
        pl_addr      = '0;
        pl_data      = '0;
        trap_req     = 1'b1;
        mret_req     = 1'b1;
        csr_op_valid = 1'b1;
        csr_op       = 2'd1;
        csr_op_addr  = 12'h305;
        csr_op_src   = 32'hFFFF_FFFF;
        csr_op_wsup  = 1'b0;
        trap_cause   = 32'h1;
        trap_pc      = 32'h0;
        trap_val     = 32'h0;
        #1;
        chk("rst we t0", 32'(csr_w_en), 0);
        repeat (2) begin
            cyc();
            chk("rst we", 32'(csr_w_en), 0);
        end
        trap_req     = 1'b0;
        mret_req     = 1'b0;
        csr_op_valid = 1'b0;
        reset_n      = 1'b1;
        cyc();
        chk("rst done", 32'(csr_op_done), 0);
        chk("rst rdata", csr_op_rdata, 0);
        chk("rst rv", 32'(redirect_valid), 0);
        chk("rst rpc", redirect_pc, 0);
        chk("rst busy", 32'(busy), 0);
        chk("rst we out", 32'(csr_w_en), 0);
        chk("rst ready", 32'(csr_op_ready), 1);
        chk_log("rst");

        foreach (tv[i]) begin
            if (tv[i].pre_en) preload(tv[i].a, tv[i].pre);
            run_csr($sformatf("vec%0d", i), tv[i].op, tv[i].a, tv[i].src,
                    tv[i].wsup, tv[i].rd, base);
            if (tv[i].we) ew.push_back('{base, tv[i].a, tv[i].wd});
            chk_log($sformatf("vec%0d", i));
            chk($sformatf("vec%0d rf", i), rf[tv[i].a],
                tv[i].we ? tv[i].wd : tv[i].rd);
        end

        preload(12'h305, 32'h1000);
        preload(12'h300, 32'h8);
        run_trap("trap1", 32'h2, 32'h206, 32'hDEAD_BEEF, 32'h1000, base);
        ew.push_back('{base,     12'h341, 32'h204});
        ew.push_back('{base + 1, 12'h342, 32'h2});
        ew.push_back('{base + 2, 12'h343, 32'hDEAD_BEEF});
        ew.push_back('{base + 3, 12'h300, 32'h1880});
        chk_log("trap1");

        preload(12'h305, 32'h1001);
        preload(12'h300, 32'h8);
        run_trap("trap2", 32'h8000_0007, 32'h208, 32'h0, 32'h101C, base);
        ew.push_back('{base,     12'h341, 32'h208});
        ew.push_back('{base + 1, 12'h342, 32'h8000_0007});
        ew.push_back('{base + 2, 12'h343, 32'h0});
        ew.push_back('{base + 3, 12'h300, 32'h1880});
        chk_log("trap2");

        preload(12'h300, 32'h1880);
        preload(12'h341, 32'h204);
        run_mret("mret", 32'h204, base);
        ew.push_back('{base, 12'h300, 32'h1888});
        chk_log("mret");

        preload(12'h305, 32'h2000);
        preload(12'h300, 32'h0);
        preload(12'h340, 32'h10);
        trap_req     = 1'b1;
        mret_req     = 1'b1;
        csr_op_valid = 1'b1;
        csr_op       = 2'd2;
        csr_op_addr  = 12'h340;
        csr_op_src   = 32'h1;
        csr_op_wsup  = 1'b0;
        trap_cause   = 32'd11;
        trap_pc      = 32'h300;
        trap_val     = 32'h0;
        #1;
        chk("all3 ready", 32'(csr_op_ready), 0);
        cyc();
        base     = cyc_cnt;
        trap_req = 1'b0;
        mret_req = 1'b0;
        for (int k = 0; k < 5; k++) begin
            chk("all3 held ready", 32'(csr_op_ready), 0);
            chk("all3 held done", 32'(csr_op_done), 0);
            cyc();
        end
        chk("all3 rv", 32'(redirect_valid), 1);
        chk("all3 rpc", redirect_pc, 32'h2000);
        chk("all3 ready rv", 32'(csr_op_ready), 1);
        cyc();
        csr_op_valid = 1'b0;
        chk("all3 done", 32'(csr_op_done), 1);
        chk("all3 rdata", csr_op_rdata, 32'h10);
        cyc();
        ew.push_back('{base,     12'h341, 32'h300});
        ew.push_back('{base + 1, 12'h342, 32'd11});
        ew.push_back('{base + 2, 12'h343, 32'h0});
        ew.push_back('{base + 3, 12'h300, 32'h1800});
        ew.push_back('{base + 6, 12'h340, 32'h11});
        chk_log("all3");

        preload(12'h305, 32'h3000);
        preload(12'h300, 32'h8);
        trap_req   = 1'b1;
        trap_cause = 32'd5;
        trap_pc    = 32'h404;
        trap_val   = 32'h77;
        cyc();
        base     = cyc_cnt;
        trap_req = 1'b0;
        cyc();
        reset_n = 1'b0;
        #1;
        chk("midrst we", 32'(csr_w_en), 0);
        cyc();
        reset_n = 1'b1;
        chk("midrst busy", 32'(busy), 0);
        for (int k = 0; k < 8; k++) begin
            chk("midrst rv", 32'(redirect_valid), 0);
            cyc();
        end
        ew.push_back('{base, 12'h341, 32'h404});
        chk_log("midrst");
        chk("midrst mepc", rf[12'h341], 32'h404);
        chk("midrst mstatus", rf[12'h300], 32'h8);

        for (int i = 0; i < 6; i++) preload(alist[i], $urandom);
        for (int t = 0; t < 60; t++) begin
            if ($urandom_range(0, 3) == 0) begin
                a = alist[$urandom_range(0, 5)];
                d = $urandom;
                if (a == 12'h305 && $urandom_range(0, 1) == 1) d[1:0] = 2'b01;
                preload(a, d);
            end
            kind = $urandom_range(0, 9);
            if (kind <= 2) begin
                irq = 1'($urandom_range(0, 1));
                cs  = irq ? (32'h8000_0000 | $urandom_range(0, 31))
                          : 32'($urandom_range(0, 15));
                d   = $urandom;
                v   = $urandom;
                s   = m_rf[12'h300];
                tg  = m_tgt(m_rf[12'h305], cs);
                run_trap("rtrap", cs, d, v, tg, base);
                ew.push_back('{base,     12'h341, d - (d % 4)});
                ew.push_back('{base + 1, 12'h342, cs});
                ew.push_back('{base + 2, 12'h343, v});
                ew.push_back('{base + 3, 12'h300, m_trap_st(s)});
                m_rf[12'h341] = d - (d % 4);
                m_rf[12'h342] = cs;
                m_rf[12'h343] = v;
                m_rf[12'h300] = m_trap_st(s);
                chk_log("rtrap");
            end else if (kind == 3) begin
                s = m_rf[12'h300];
                run_mret("rmret", m_rf[12'h341] - (m_rf[12'h341] % 4), base);
                ew.push_back('{base, 12'h300, m_mret_st(s)});
                m_rf[12'h300] = m_mret_st(s);
                chk_log("rmret");
            end else begin
                a  = alist[$urandom_range(0, 5)];
                op = 2'($urandom_range(0, 3));
                d  = $urandom;
                ws = ($urandom_range(0, 4) == 0);
                o  = m_rf[a];
                nv = m_csr(op, o, d);
                run_csr("rcsr", op, a, d, ws, o, base);
                if (!ws && op != 2'd0) begin
                    ew.push_back('{base, a, nv});
                    m_rf[a] = nv;
                end
                chk_log("rcsr");
            end
            if ($urandom_range(0, 2) == 0) cyc();
        end
        for (int i = 0; i < 6; i++) chk("final rf", rf[alist[i]], m_rf[alist[i]]);

        chk("we in idle", 32'(bad_idle), 0);
        chk("we in reset", 32'(bad_rst), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
